// File: rtl/dm_ctrl_if.sv
// Pipeline-side request/response and memory-side bus of the data-memory controller.
// The controller uses the master view; the pipeline/memory environment uses the slave view.
interface dm_ctrl_if;
  logic        Req;
  logic [5:0]  Op;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Stall;
  logic        Done;
  logic [31:0] RData;
  logic        AdEL;
  logic        AdES;
  logic        BusErr;
  logic        MemReq;
  logic        MemWE;
  logic [3:0]  MemBE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    input  Req, Op, Addr, WData, MemRData, MemAck,
    output Stall, Done, RData, AdEL, AdES, BusErr,
    output MemReq, MemWE, MemBE, MemAddr, MemWData
  );

  modport slave (
    output Req, Op, Addr, WData, MemRData, MemAck,
    input  Stall, Done, RData, AdEL, AdES, BusErr,
    input  MemReq, MemWE, MemBE, MemAddr, MemWData
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory access controller: decodes load/store requests, checks alignment,
// runs a single-outstanding memory handshake with timeout and extends load data.
module dm_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  dm_ctrl_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] EXC  = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_sz;
  logic        r_uns;
  logic        r_we;
  logic [1:0]  r_lo;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_buserr;

  logic        w_known;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_accept;
  logic        w_busy;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rdata;

  // Op[1:0] encodes size (00 byte, 01 half, 11 word), Op[2] unsigned load, Op[3] store.
  always_comb begin
    w_known = 1'b0;
    case (bus.Op)
      6'b100000, 6'b100100, 6'b100001, 6'b100101,
      6'b100011, 6'b101000, 6'b101001, 6'b101011: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = bus.WData;
    case (bus.Op[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.Addr[1:0];
        w_wdata = {4{bus.WData[7:0]}};
      end
      2'b01: begin
        w_misal = bus.Addr[0];
        w_be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.WData[15:0]}};
      end
      default: w_misal = |bus.Addr[1:0];
    endcase
  end

  assign w_accept  = (r_state == IDLE) && bus.Req && w_known;
  assign w_busy    = (r_state == BUSY);
  assign w_timeout = w_busy && !bus.MemAck && (r_cnt == TIMEOUT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_misal ? EXC : BUSY;
      BUSY: begin
        if (bus.MemAck)     w_state_nxt = RESP;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sz     <= 2'b00;
      r_uns    <= 1'b0;
      r_we     <= 1'b0;
      r_lo     <= 2'b00;
      r_addr   <= 32'd0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_cnt    <= 8'd0;
      r_buserr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buserr <= w_timeout;
      if (w_accept) begin
        r_sz    <= bus.Op[1:0];
        r_uns   <= bus.Op[2];
        r_we    <= bus.Op[3];
        r_lo    <= bus.Addr[1:0];
        r_addr  <= {bus.Addr[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_cnt   <= 8'd0;
      end
      if (w_busy) begin
        if (bus.MemAck) r_rdata <= bus.MemRData;
        else            r_cnt   <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    case (r_lo)
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_sz)
      2'b00:   w_rdata = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_rdata = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_rdata = r_rdata;
    endcase
  end

  assign bus.Stall    = w_accept || w_busy;
  assign bus.Done     = (r_state == RESP);
  assign bus.RData    = ((r_state == RESP) && !r_we) ? w_rdata : 32'd0;
  assign bus.AdEL     = (r_state == EXC) && !r_we;
  assign bus.AdES     = (r_state == EXC) && r_we;
  assign bus.BusErr   = r_buserr;
  assign bus.MemReq   = w_busy;
  assign bus.MemWE    = w_busy && r_we;
  assign bus.MemBE    = w_busy ? r_be : 4'b0000;
  assign bus.MemAddr  = r_addr;
  assign bus.MemWData = r_wdata;

endmodule

// File: tb/tb_dm_ctrl.sv
// Randomized bench for dm_ctrl against a size/offset arithmetic model of each access.
module tb_dm_ctrl;

  localparam int TO = 4;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dm_ctrl_if bus ();

  dm_ctrl #(.TIMEOUT(TO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: an access touches sz bytes starting at byte offset off of the word.
  task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd, output bit kn, output bit st, output bit mis,
                       output logic [3:0] be, output logic [31:0] wd, output logic [31:0] erd);
    int sz;
    int off;
    bit sg;
    logic [31:0] mask;
    logic [31:0] v;
    kn = 1'b1; st = 1'b0; sg = 1'b0; sz = 1;
    case (op)
      OP_LB:   begin sz = 1; sg = 1'b1; end
      OP_LBU:  sz = 1;
      OP_LH:   begin sz = 2; sg = 1'b1; end
      OP_LHU:  sz = 2;
      OP_LW:   sz = 4;
      OP_SB:   begin sz = 1; st = 1'b1; end
      OP_SH:   begin sz = 2; st = 1'b1; end
      OP_SW:   begin sz = 4; st = 1'b1; end
      default: kn = 1'b0;
    endcase
    off  = int'(addr % 32'd4);
    mis  = (off % sz) != 0;
    be   = 4'(((1 << sz) - 1) << off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
    if (sz == 1)      wd = (wdata & mask) * 32'h0101_0101;
    else if (sz == 2) wd = (wdata & mask) * 32'h0001_0001;
    else              wd = wdata;
    v = (rd >> (8 * off)) & mask;
    if (sg && v[8 * sz - 1]) v = v | ~mask;
    erd = st ? 32'd0 : v;
  endtask

  // delay: BUSY cycle (1..TO) in which MemAck is given; 0 = never.
  // poke: present a fresh valid Req in the RESP/EXC cycle, which must be ignored.
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rd, input bit poke);
    bit kn, st, mis;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_rd;
    model(op, addr, wdata, rd, kn, st, mis, e_be, e_wd, e_rd);
    @(negedge clk);
    bus.Req = 1'b1; bus.Op = op; bus.Addr = addr; bus.WData = wdata; bus.MemAck = 1'b0;
    #1 check("stall_req", 32'(bus.Stall), 32'(kn));
    @(negedge clk);
    bus.Req = 1'b0; bus.Op = 6'($urandom); bus.Addr = $urandom; bus.WData = $urandom;
    if (!kn) begin
      bus.MemAck = 1'b1;
      #1 check("ign_memreq", 32'(bus.MemReq), 32'd0);
      check("ign_exc", {30'd0, bus.AdEL, bus.AdES}, 32'd0);
      check("ign_done", 32'(bus.Done), 32'd0);
      bus.MemAck = 1'b0;
      return;
    end
    if (mis) begin
      if (poke) begin bus.Req = 1'b1; bus.Op = OP_LW; bus.Addr = 32'h0000_0100; end
      #1 check("adel", 32'(bus.AdEL), 32'(!st));
      check("ades", 32'(bus.AdES), 32'(st));
      check("exc_memreq", 32'(bus.MemReq), 32'd0);
      check("exc_done", 32'(bus.Done), 32'd0);
      check("exc_stall", 32'(bus.Stall), 32'd0);
      @(negedge clk);
      bus.Req = 1'b0;
      #1 check("exc_end", {29'd0, bus.AdEL, bus.AdES, bus.MemReq}, 32'd0);
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      bus.MemAck   = (k == delay);
      bus.MemRData = (k == delay) ? rd : $urandom;
      #1 check("memreq", 32'(bus.MemReq), 32'd1);
      check("memwe", 32'(bus.MemWE), 32'(st));
      check("membe", 32'(bus.MemBE), 32'(e_be));
      check("memaddr", bus.MemAddr, addr & ~32'd3);
      check("memwdata", bus.MemWData, e_wd);
      check("busy_flags", {29'd0, bus.Stall, bus.Done, bus.BusErr}, 32'd4);
      @(negedge clk);
      if (k == delay) break;
    end
    bus.MemAck = 1'($urandom);
    if (poke && delay != 0) begin bus.Req = 1'b1; bus.Op = OP_SW; bus.Addr = 32'h0000_0200; end
    #1 check("end_memreq", 32'(bus.MemReq), 32'd0);
    check("end_stall", 32'(bus.Stall), 32'd0);
    if (delay != 0) begin
      check("done", 32'(bus.Done), 32'd1);
      check("rdata", bus.RData, e_rd);
      check("resp_buserr", 32'(bus.BusErr), 32'd0);
    end else begin
      check("buserr", 32'(bus.BusErr), 32'd1);
      check("to_done", 32'(bus.Done), 32'd0);
    end
    @(negedge clk);
    bus.Req = 1'b0; bus.MemAck = 1'b0;
    #1 check("after", {28'd0, bus.Done, bus.BusErr, bus.MemReq, bus.Stall}, 32'd0);
  endtask

  task automatic reset_mid(input bit in_resp);
    @(negedge clk);
    bus.Req = 1'b1; bus.Op = OP_LW; bus.Addr = 32'h0000_0040; bus.MemAck = 1'b0;
    @(negedge clk);
    bus.Req = 1'b0;
    if (in_resp) begin
      bus.MemAck = 1'b1; bus.MemRData = $urandom;
      @(negedge clk);
      bus.MemAck = 1'b0;
      #1 check("rst_pre_done", 32'(bus.Done), 32'd1);
    end else begin
      @(negedge clk);
      #1 check("rst_pre_memreq", 32'(bus.MemReq), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_memreq", 32'(bus.MemReq), 32'd0);
    check("rst_flags", {28'd0, bus.Done, bus.BusErr, bus.Stall, bus.MemWE}, 32'd0);
    check("rst_membe", 32'(bus.MemBE), 32'd0);
    check("rst_rdata", bus.RData, 32'd0);
    @(negedge clk);
    #1 check("rst_after", {29'd0, bus.Done, bus.BusErr, bus.MemReq}, 32'd0);
  endtask

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [31:0] addr;
    n_checks = 0;
    n_fail   = 0;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    reset = 1'b1;
    bus.Req = 1'b0; bus.Op = 6'd0; bus.Addr = 32'd0; bus.WData = 32'd0;
    bus.MemRData = 32'd0; bus.MemAck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check("reset_flags", {26'd0, bus.Stall, bus.Done, bus.AdEL, bus.AdES, bus.BusErr,
                              bus.MemReq}, 32'd0);
    check("reset_we", 32'(bus.MemWE), 32'd0);
    check("reset_be", 32'(bus.MemBE), 32'd0);
    check("reset_rdata", bus.RData, 32'd0);

    do_access(OP_LB,  32'h0000_1003, 32'h0, 1, 32'h80FF_0000, 1'b0);
    do_access(OP_SH,  32'h0000_2002, 32'h0000_BEEF, 1, 32'h1234_5678, 1'b0);
    do_access(OP_LW,  32'h0000_3001, 32'h0, 1, 32'h0, 1'b0);
    do_access(OP_SH,  32'h0000_3001, 32'h0, 1, 32'h0, 1'b1);
    do_access(OP_LHU, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b0);
    do_access(OP_LBU, 32'h0000_0005, 32'h0, 3, 32'h0000_AB00, 1'b1);
    do_access(OP_LH,  32'h0000_0042, 32'h0, TO, 32'h8001_7FFF, 1'b0);
    do_access(6'b000000, 32'h0, 32'h0, 1, 32'h0, 1'b0);
    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 200; i++) begin
      op   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
      do_access(op, addr, $urandom, $urandom_range(0, TO), $urandom, 1'($urandom));
      if ($urandom_range(0, 39) == 0) reset_mid(1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
